// File: rtl/axi_b_arb_pkg.sv
// Shared bus definitions for the write-response path: ID width and BRESP codes.
package axi_b_arb_pkg;

    localparam int BUS_ID_W = 4;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } bresp_e;

endpackage

// File: rtl/axi_b_fifo2.sv
// Two-entry FIFO with registered storage; reusable for any AXI response channel.
module axi_b_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] mem0, mem1;
    logic         wr_ptr, rd_ptr;
    logic [1:0]   cnt;
    logic         do_push, do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop_i && (cnt != 2'd0);
    assign do_push = push_i && ((cnt != 2'd2) || do_pop);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            mem0   <= '0;
            mem1   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                if (wr_ptr) mem1 <= din_i;
                else        mem0 <= din_i;
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            if (do_push && !do_pop)
                cnt <= cnt + 2'd1;
            else if (!do_push && do_pop)
                cnt <= cnt - 2'd1;
        end
    end

    assign dout_o  = rd_ptr ? mem1 : mem0;
    assign full_o  = (cnt == 2'd2);
    assign empty_o = (cnt == 2'd0);

endmodule

// File: rtl/axi_b_arb.sv
// Round-robin merge of N downstream AXI B channels onto one upstream B channel,
// buffered through a 2-entry FIFO, with a saturating non-OKAY response counter.
module axi_b_arb
    import axi_b_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int ERRCNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic [N*BUS_ID_W-1:0] s_bid_i,
    input  logic [2*N-1:0]        s_bresp_i,
    input  logic [N-1:0]          s_bvalid_i,
    output logic [N-1:0]          s_bready_o,
    output logic [BUS_ID_W-1:0]   m_bid_o,
    output logic [1:0]            m_bresp_o,
    output logic                  m_bvalid_o,
    input  logic                  m_bready_i,
    output logic [ERRCNT_W-1:0]   err_cnt_o,
    input  logic                  err_clr_i
);

    localparam int PW = $clog2(N);
    localparam int DW = BUS_ID_W + 2;

    logic [PW-1:0]   ptr, off, win, ptr_nxt;
    logic [PW:0]     sum;
    logic [N-1:0]    rot;
    logic [2*N-1:0]  dbl;
    logic            any, grant, full, empty, pop;
    logic [1:0]      push_resp;
    logic [DW-1:0]   push_data, head;
    logic [ERRCNT_W-1:0] err_cnt;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
    always_comb begin
        dbl = {s_bvalid_i, s_bvalid_i};
        rot = N'(dbl >> ptr);
        off = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = PW'(i);
                any = 1'b1;
            end
        end
        sum = {1'b0, off} + {1'b0, ptr};
        win = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
    end

    // Grant never looks at m_bready_i, keeping the upstream ready off the downstream path.
    assign grant      = any && !full && !arst_i;
    assign s_bready_o = grant ? ({{(N-1){1'b0}}, 1'b1} << win) : '0;
    assign ptr_nxt    = (win == PW'(N - 1)) ? '0 : win + PW'(1);

    assign push_resp = s_bresp_i[win*2 +: 2];
    assign push_data = {s_bid_i[win*BUS_ID_W +: BUS_ID_W], push_resp};
    assign pop       = !empty && m_bready_i;

    axi_b_fifo2 #(.W(DW)) u_fifo (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .push_i  (grant),
        .pop_i   (pop),
        .din_i   (push_data),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ptr     <= '0;
            err_cnt <= '0;
        end else begin
            if (grant)
                ptr <= ptr_nxt;
            if (err_clr_i)
                err_cnt <= '0;
            else if (grant && (push_resp != RESP_OKAY) && (err_cnt != '1))
                err_cnt <= err_cnt + ERRCNT_W'(1);
        end
    end

    assign m_bvalid_o = !empty;
    assign m_bid_o    = head[DW-1:2];
    assign m_bresp_o  = head[1:0];
    assign err_cnt_o  = err_cnt;

endmodule

// File: tb/tb_axi_b_arb.sv
// Bench for axi_b_arb: directed vector table, hand-written corner sequences,
// and a randomized run against a queue-based reference model.
module tb_axi_b_arb;
    import axi_b_arb_pkg::*;

    localparam int N = 4;

    logic                  clk = 1'b0;
    logic                  arst;
    logic [BUS_ID_W-1:0]   bid_a  [N];
    logic [1:0]            resp_a [N];
    logic [N-1:0]          vld;
    logic                  mrdy;
    logic                  clr;
    logic [N*BUS_ID_W-1:0] s_bid;
    logic [2*N-1:0]        s_bresp;

    logic [N-1:0]          s_bready;
    logic [BUS_ID_W-1:0]   m_bid;
    logic [1:0]            m_bresp;
    logic                  m_bvalid;
    logic [15:0]           err_cnt;

    logic [N-1:0]          sat_bready;
    logic [BUS_ID_W-1:0]   sat_bid;
    logic [1:0]            sat_bresp;
    logic                  sat_bvalid;
    logic [1:0]            sat_err;

    int n_cmp = 0;
    int n_bad = 0;

    assign s_bid   = {bid_a[3], bid_a[2], bid_a[1], bid_a[0]};
    assign s_bresp = {resp_a[3], resp_a[2], resp_a[1], resp_a[0]};

    always #5 clk = ~clk;

    axi_b_arb #(.N(N), .ERRCNT_W(16)) u_dut (
        .clk_i(clk), .arst_i(arst), .s_bid_i(s_bid), .s_bresp_i(s_bresp),
        .s_bvalid_i(vld), .s_bready_o(s_bready), .m_bid_o(m_bid),
        .m_bresp_o(m_bresp), .m_bvalid_o(m_bvalid), .m_bready_i(mrdy),
        .err_cnt_o(err_cnt), .err_clr_i(clr)
    );

    axi_b_arb #(.N(N), .ERRCNT_W(2)) u_sat (
        .clk_i(clk), .arst_i(arst), .s_bid_i(s_bid), .s_bresp_i(s_bresp),
        .s_bvalid_i(vld), .s_bready_o(sat_bready), .m_bid_o(sat_bid),
        .m_bresp_o(sat_bresp), .m_bvalid_o(sat_bvalid), .m_bready_i(mrdy),
        .err_cnt_o(sat_err), .err_clr_i(clr)
    );

    typedef struct {
        logic [3:0] v;
        logic       r;
        logic [3:0] sr;
        logic       mv;
        logic [3:0] bid;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_one(input int src, input logic [1:0] resp, input logic c);
        int tries;
        tries = 0;
        vld = '0;
        vld[src] = 1'b1;
        bid_a[src] = 4'(src + 3);
        resp_a[src] = resp;
        clr = c;
        mrdy = 1'b1;
        #1;
        while (!s_bready[src] && tries < 8) begin
            step();
            tries++;
        end
        chk("push_grant", 32'(s_bready[src]), 32'd1);
        step();
        vld = '0;
        clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [5:0] q[$];
        logic [N-1:0] pv;
        int wait_g [N];
        int rr, w, j;
        int errs;
        logic [3:0] exp_sr;

        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 4'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 4'd3};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 4'd4};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 4'd5};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'd6};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 4'd3};
        tbl[6]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 4'd0};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 4'd5};
        tbl[8]  = '{4'b0011, 1'b0, 4'b0001, 1'b0, 4'd0};
        tbl[9]  = '{4'b0011, 1'b0, 4'b0010, 1'b1, 4'd3};
        tbl[10] = '{4'b0111, 1'b0, 4'b0000, 1'b1, 4'd3};
        tbl[11] = '{4'b0111, 1'b0, 4'b0000, 1'b1, 4'd3};
        tbl[12] = '{4'b0111, 1'b1, 4'b0000, 1'b1, 4'd3};
        tbl[13] = '{4'b0111, 1'b1, 4'b0100, 1'b1, 4'd4};
        tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 4'd5};
        tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'd0};

        arst = 1'b1;
        clr  = 1'b0;
        mrdy = 1'b1;
        vld  = 4'b1111;
        for (int k = 0; k < N; k++) begin
            bid_a[k]  = 4'(k + 3);
            resp_a[k] = 2'd0;
        end
        #3;
        chk("rst_bready", 32'(s_bready), 32'd0);
        chk("rst_bvalid", 32'(m_bvalid), 32'd0);
        chk("rst_bid", 32'(m_bid), 32'd0);
        chk("rst_bresp", 32'(m_bresp), 32'd0);
        chk("rst_errcnt", 32'(err_cnt), 32'd0);
        vld = '0;
        step();
        step();
        arst = 1'b0;

        // Fairness, single response and backpressure rows.
        for (int i = 0; i < 16; i++) begin
            vld  = tbl[i].v;
            mrdy = tbl[i].r;
            #1;
            chk($sformatf("tbl%0d_bready", i), 32'(s_bready), 32'(tbl[i].sr));
            chk($sformatf("tbl%0d_bvalid", i), 32'(m_bvalid), 32'(tbl[i].mv));
            if (tbl[i].mv) begin
                chk($sformatf("tbl%0d_bid", i), 32'(m_bid), 32'(tbl[i].bid));
                chk($sformatf("tbl%0d_bresp", i), 32'(m_bresp), 32'd0);
            end
            chk($sformatf("tbl%0d_errcnt", i), 32'(err_cnt), 32'd0);
            step();
        end

        // Error counting, clear priority and saturation.
        push_one(0, 2'd2, 1'b0);
        push_one(1, 2'd3, 1'b0);
        push_one(2, 2'd0, 1'b0);
        push_one(3, 2'd1, 1'b0);
        chk("err_cnt_3", 32'(err_cnt), 32'd3);
        chk("sat_cnt_3", 32'(sat_err), 32'd3);
        push_one(0, 2'd2, 1'b1);
        chk("err_clr", 32'(err_cnt), 32'd0);
        chk("sat_clr", 32'(sat_err), 32'd0);
        for (int k = 0; k < 5; k++)
            push_one(k % N, 2'd3, 1'b0);
        chk("err_cnt_5", 32'(err_cnt), 32'd5);
        chk("sat_cnt_sat", 32'(sat_err), 32'd3);

        // Asynchronous reset with the buffer full.
        vld = '0;
        mrdy = 1'b1;
        step();
        step();
        mrdy = 1'b0;
        vld = 4'b0011;
        step();
        step();
        #1;
        chk("full_bready", 32'(s_bready), 32'd0);
        chk("full_bvalid", 32'(m_bvalid), 32'd1);
        #1;
        arst = 1'b1;
        #1;
        chk("arst_bvalid", 32'(m_bvalid), 32'd0);
        chk("arst_bready", 32'(s_bready), 32'd0);
        chk("arst_errcnt", 32'(err_cnt), 32'd0);
        vld = 4'b1111;
        step();
        arst = 1'b0;
        #1;
        chk("post_rst_grant", 32'(s_bready), 32'd1);
        vld = '0;

        // Randomized traffic against the reference model.
        arst = 1'b1;
        #1;
        arst = 1'b0;
        step();
        rr = 0;
        errs = 0;
        pv = '0;
        for (int k = 0; k < N; k++) wait_g[k] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!pv[k] && ($urandom_range(0, 1) == 1)) begin
                    pv[k]     = 1'b1;
                    bid_a[k]  = 4'($urandom_range(0, 15));
                    resp_a[k] = 2'($urandom_range(0, 3));
                    wait_g[k] = 0;
                end
            end
            vld  = pv;
            mrdy = ($urandom_range(0, 3) != 0);
            #1;
            w = -1;
            if (q.size() < 2) begin
                for (int i = 0; i < N; i++) begin
                    j = (rr + i) % N;
                    if (w < 0 && pv[j]) w = j;
                end
            end
            exp_sr = (w >= 0) ? 4'(1 << w) : 4'd0;
            chk("rnd_bready", 32'(s_bready), 32'(exp_sr));
            chk("rnd_bvalid", 32'(m_bvalid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("rnd_bid", 32'(m_bid), 32'(q[0][5:2]));
                chk("rnd_bresp", 32'(m_bresp), 32'(q[0][1:0]));
            end
            chk("rnd_errcnt", 32'(err_cnt), 32'(errs));
            chk("rnd_satcnt", 32'(sat_err), 32'((errs > 3) ? 3 : errs));
            step();
            if (q.size() != 0 && mrdy)
                void'(q.pop_front());
            if (w >= 0) begin
                for (int k = 0; k < N; k++)
                    if (pv[k]) wait_g[k]++;
                chk("rnd_starve", 32'(wait_g[w] <= N), 32'd1);
                q.push_back({bid_a[w], resp_a[w]});
                if (resp_a[w] != 2'd0 && errs < 65535) errs++;
                rr = (w + 1) % N;
                pv[w] = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
